// File: rtl/cache_line_bus_ctrl_pkg.sv
// Shared types and constants for the cache line bus controller.
// Default geometry is a 512-bit line moved as 64-bit beats.
package config_pkg;

  localparam int PA_BITS_DEF  = 56;
  localparam int LINELEN_DEF  = 512;
  localparam int BEATLEN_DEF  = 64;
  localparam int LOGBWPL_DEF  = 3;
  localparam int BEATSPERLINE = LINELEN_DEF / BEATLEN_DEF;

  localparam logic [1:0] BUSRW_FETCH = 2'b10;
  localparam logic [1:0] BUSRW_WB    = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } busfsm_state_t;

endpackage

// File: rtl/cache_line_bus_ctrl_beat_counter.sv
// Beat index counter: enabled register with synchronous reset and clear,
// plus a terminal-count flag that marks the last beat of the line.
module beat_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (en)        count <= count + 1'b1;
  end

  assign tc = &count;

endmodule

// File: rtl/cache_line_bus_ctrl.sv
// Splits whole-line fetch/writeback requests from the cache into beats on a
// valid/ready fabric bus and assembles fetched beats into FetchBuffer.
module cache_line_bus_ctrl
  import config_pkg::*;
#(
  parameter int PA_BITS = PA_BITS_DEF,
  parameter int LINELEN = LINELEN_DEF,
  parameter int BEATLEN = BEATLEN_DEF,
  parameter int LOGBWPL = LOGBWPL_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [BEATLEN-1:0] CacheReadDataWord,
  output logic               CacheBusAck,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic               SelBusBeat,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               BusValid,
  output logic               BusWrite,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [BEATLEN-1:0] BusWData,
  input  logic               BusReady,
  input  logic [BEATLEN-1:0] BusRData
);

  localparam int BPL     = LINELEN / BEATLEN;
  localparam int LINEOFF = $clog2(LINELEN / 8);
  localparam int BEATOFF = $clog2(BEATLEN / 8);

  busfsm_state_t state, nextState;
  logic busy, beatDone, lastBeat, cntClear, readBeat;
  logic [BPL-1:0]     beatSel;
  logic [LINEOFF-1:0] lineOff;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Writeback wins over fetch when both are requested; the fetch stays pending.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if ((CacheBusRW & BUSRW_WB) != 2'b00)         nextState = WRITE;
        else if ((CacheBusRW & BUSRW_FETCH) != 2'b00) nextState = READ;
      end
      READ, WRITE: if (beatDone && lastBeat) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are forced quiet during reset so no beat leaks out mid-burst.
  always_comb begin
    busy        = (state != IDLE) && !reset;
    BusValid    = busy;
    BusWrite    = (state == WRITE) && !reset;
    SelBusBeat  = (state == WRITE) && !reset;
    beatDone    = busy && BusReady;
    readBeat    = beatDone && (state == READ);
    CacheBusAck = beatDone && lastBeat;
    cntClear    = (state == IDLE);
  end

  beat_counter #(.WIDTH(LOGBWPL)) u_beatCounter (
    .clk   (clk),
    .reset (reset),
    .clear (cntClear),
    .en    (beatDone),
    .count (BeatCount),
    .tc    (lastBeat)
  );

  // Offset add is confined to the line-offset bits so the tag never carries.
  assign lineOff  = CacheBusAdr[LINEOFF-1:0] + LINEOFF'({BeatCount, {BEATOFF{1'b0}}});
  assign BusAdr   = {CacheBusAdr[PA_BITS-1:LINEOFF], lineOff};
  assign BusWData = CacheReadDataWord;

  assign beatSel = {{(BPL-1){1'b0}}, 1'b1} << BeatCount;

  always_ff @(posedge clk) begin
    if (reset) FetchBuffer <= '0;
    else begin
      for (int b = 0; b < BPL; b++)
        if (readBeat && beatSel[b]) FetchBuffer[b*BEATLEN +: BEATLEN] <= BusRData;
    end
  end

`ifndef SYNTHESIS
  // The request must stay asserted for the whole burst.
  always @(posedge clk) begin
    if (!reset) begin
      if (state == READ)  assert (CacheBusRW[1]);
      if (state == WRITE) assert (CacheBusRW[0]);
    end
  end
`endif

endmodule

// File: tb/tb_cache_line_bus_ctrl.sv
// Self-checking bench for cache_line_bus_ctrl: directed vector table, corner
// sequences, and random traffic against a line-level reference model.
module tb_cache_line_bus_ctrl;

  localparam int PA = 34;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    rwIn;
  logic [PA-1:0] adrIn;
  logic [63:0]   wdIn;
  logic          ackOut;
  logic [2:0]    cntOut;
  logic          selOut;
  logic [511:0]  fbOut;
  logic          validOut;
  logic          writeOut;
  logic [PA-1:0] busAdrOut;
  logic [63:0]   busWdOut;
  logic          rdyIn;
  logic [63:0]   rdIn;

  int nAssert = 0;
  int nFail   = 0;

  // Reference model: current operation, beat index, and the fetched line.
  int          mMode = 0;   // 0 none, 1 fetching, 2 writing back
  int          mBeat = 0;
  logic [63:0] mLine [8];

  always #5 clk = ~clk;

  cache_line_bus_ctrl #(.PA_BITS(PA), .LINELEN(512), .BEATLEN(64), .LOGBWPL(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .CacheBusRW        (rwIn),
    .CacheBusAdr       (adrIn),
    .CacheReadDataWord (wdIn),
    .CacheBusAck       (ackOut),
    .BeatCount         (cntOut),
    .SelBusBeat        (selOut),
    .FetchBuffer       (fbOut),
    .BusValid          (validOut),
    .BusWrite          (writeOut),
    .BusAdr            (busAdrOut),
    .BusWData          (busWdOut),
    .BusReady          (rdyIn),
    .BusRData          (rdIn)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkLine(input string nm, input logic [511:0] act, input logic [511:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] modelLine();
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = mLine[i];
    return l;
  endfunction

  // One clock: drive inputs, compare every output with the model, advance model.
  task automatic cycle(input logic r, input logic [1:0] rw, input logic [PA-1:0] adr,
                       input logic rdy, input logic [63:0] rd, input logic [63:0] wd,
                       output logic ackExp);
    logic pValid, pWrite;
    logic [PA-1:0] pAdr;
    @(negedge clk);
    reset = r; rwIn = rw; adrIn = adr; rdyIn = rdy; rdIn = rd; wdIn = wd;
    #1;
    pValid = (mMode != 0) && !r;
    pWrite = (mMode == 2) && !r;
    pAdr   = adr + PA'(mBeat * 8);
    ackExp = pValid && rdy && (mBeat == 7);
    chk("BusValid",    validOut,  pValid);
    chk("BusWrite",    writeOut,  pWrite);
    chk("SelBusBeat",  selOut,    pWrite);
    chk("BusAdr",      busAdrOut, pAdr);
    chk("BusWData",    busWdOut,  wd);
    chk("CacheBusAck", ackOut,    ackExp);
    chk("BeatCount",   cntOut,    mBeat);
    chkLine("FetchBuffer", fbOut, modelLine());
    if (r) begin
      mMode = 0; mBeat = 0;
      for (int i = 0; i < 8; i++) mLine[i] = '0;
    end else if (mMode == 0) begin
      mBeat = 0;
      if (rw[0])      mMode = 2;
      else if (rw[1]) mMode = 1;
    end else if (rdy) begin
      if (mMode == 1) mLine[mBeat] = rd;
      if (mBeat == 7) mMode = 0;
      mBeat = (mBeat + 1) % 8;
    end
  endtask

  typedef struct {
    logic [1:0]  rw;
    logic        rdy;
    logic [63:0] rd;
    logic        expValid;
    logic [PA-1:0] expAdr;
    logic        expAck;
    logic [2:0]  expCnt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic a;
    logic [1:0] curRw;
    logic [PA-1:0] curAdr;
    int gap, ackCyc, ackCyc2, wrBeats, rdBeats, selCyc, acks, idleGap, phase;
    logic [63:0] words [8];
    logic [PA-1:0] adr7;
    logic done;

    for (int i = 0; i < 8; i++) mLine[i] = '0;
    reset = 1'b1; rwIn = 2'b00; adrIn = '0; rdyIn = 1'b0; rdIn = '0; wdIn = '0;
    repeat (2) @(posedge clk);

    // Reset state
    cycle(1'b1, 2'b00, '0, 1'b1, '0, '0, a);
    chk("reset_valid", validOut, 1'b0);
    chk("reset_cnt", cntOut, 3'd0);
    chkLine("reset_fb", fbOut, '0);
    cycle(1'b0, 2'b00, '0, 1'b0, '0, '0, a);

    // Fetch, zero-wait, from a vector table
    tbl[0] = '{2'b10, 1'b0, 64'd0, 1'b0, 34'h0_8000_0040, 1'b0, 3'd0};
    for (int k = 1; k <= 8; k++)
      tbl[k] = '{2'b10, 1'b1, 64'(k-1), 1'b1, 34'h0_8000_0040 + PA'(8*(k-1)), (k == 8), 3'(k-1)};
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, tbl[k].rw, 34'h0_8000_0040, tbl[k].rdy, tbl[k].rd, 64'h0, a);
      chk("tbl_valid", validOut, tbl[k].expValid);
      chk("tbl_adr", busAdrOut, tbl[k].expAdr);
      chk("tbl_ack", ackOut, tbl[k].expAck);
      chk("tbl_cnt", cntOut, tbl[k].expCnt);
    end
    cycle(1'b0, 2'b00, 34'h0_8000_0040, 1'b0, '0, '0, a);
    for (int k = 0; k < 8; k++) chk("tbl_fbword", fbOut[k*64 +: 64], 64'(k));

    // Writeback with two wait cycles per beat
    ackCyc = -1; wrBeats = 0; selCyc = 0; phase = 0; done = 1'b0;
    cycle(1'b0, 2'b01, 34'h1_2345_6700, 1'b0, '0, 64'hA5A5_0000_0000_0000, a);
    for (int c = 1; c <= 60 && !done; c++) begin
      cycle(1'b0, 2'b01, 34'h1_2345_6700, (phase == 2), '0,
            64'hA5A5_0000_0000_0000 | 64'(mBeat), a);
      if (selOut) selCyc++;
      if (validOut && writeOut && rdyIn) wrBeats++;
      phase = (phase + 1) % 3;
      if (ackOut) begin ackCyc = c; done = 1'b1; end
    end
    cycle(1'b0, 2'b00, 34'h1_2345_6700, 1'b0, '0, '0, a);
    chk("wb_ack_cycle", ackCyc, 24);
    chk("wb_beats", wrBeats, 8);
    chk("wb_sel_cycles", selCyc, 24);

    // Combined writeback + fetch request
    curRw = 2'b11; acks = 0; wrBeats = 0; rdBeats = 0; idleGap = 0;
    ackCyc = -1; ackCyc2 = -1; done = 1'b0;
    cycle(1'b0, curRw, 34'h0_0000_1000, 1'b1, '0, '0, a);
    for (int c = 1; c <= 40 && !done; c++) begin
      cycle(1'b0, curRw, 34'h0_0000_1000, 1'b1, 64'hC0DE_0000_0000_0000 | 64'(c), 64'hBEEF, a);
      if (validOut && writeOut) wrBeats++;
      if (validOut && !writeOut) rdBeats++;
      if (!validOut && acks == 1) idleGap++;
      if (ackOut) begin
        acks++;
        if (acks == 1) ackCyc = c; else ackCyc2 = c;
        if (curRw == 2'b11) curRw = 2'b10;
        else begin curRw = 2'b00; done = 1'b1; end
      end
    end
    cycle(1'b0, 2'b00, 34'h0_0000_1000, 1'b0, '0, '0, a);
    chk("combo_acks", acks, 2);
    chk("combo_wbeats", wrBeats, 8);
    chk("combo_rbeats", rdBeats, 8);
    chk("combo_gap", idleGap, 1);
    chk("combo_ack1", ackCyc, 8);
    chk("combo_ack2", ackCyc2, 17);

    // Reset in the middle of a fetch
    cycle(1'b0, 2'b10, 34'h2_0000_0080, 1'b0, '0, '0, a);
    for (int k = 0; k < 4; k++)
      cycle(1'b0, 2'b10, 34'h2_0000_0080, 1'b1, {$urandom, $urandom}, '0, a);
    cycle(1'b1, 2'b00, 34'h2_0000_0080, 1'b1, 64'hDEAD, '0, a);
    chk("rst_cycle_valid", validOut, 1'b0);
    chk("rst_cycle_ack", ackOut, 1'b0);
    cycle(1'b0, 2'b00, 34'h2_0000_0080, 1'b1, 64'hDEAD, '0, a);
    chk("rst_valid", validOut, 1'b0);
    chk("rst_cnt", cntOut, 3'd0);
    chkLine("rst_fb", fbOut, '0);
    chk("rst_ack", ackOut, 1'b0);
    done = 1'b0;
    cycle(1'b0, 2'b10, 34'h2_0000_0080, 1'b0, '0, '0, a);
    for (int k = 0; k < 8; k++) words[k] = {$urandom, $urandom};
    for (int c = 0; c < 30 && !done; c++) begin
      cycle(1'b0, 2'b10, 34'h2_0000_0080, 1'b1, words[mBeat], '0, a);
      if (ackOut) done = 1'b1;
    end
    cycle(1'b0, 2'b00, 34'h2_0000_0080, 1'b0, '0, '0, a);
    chk("refetch_done", done, 1'b1);
    for (int k = 0; k < 8; k++) chk("refetch_word", fbOut[k*64 +: 64], words[k]);

    // Line at the top of a 32-bit region and at the top of the address space
    for (int t = 0; t < 2; t++) begin
      curAdr = (t == 0) ? 34'h0_FFFF_FFC0 : 34'h3_FFFF_FFC0;
      adr7 = '0; done = 1'b0;
      cycle(1'b0, 2'b10, curAdr, 1'b1, '0, '0, a);
      for (int c = 0; c < 20 && !done; c++) begin
        cycle(1'b0, 2'b10, curAdr, 1'b1, 64'(c), '0, a);
        if (validOut && cntOut == 3'd7) adr7 = busAdrOut;
        if (ackOut) done = 1'b1;
      end
      cycle(1'b0, 2'b00, curAdr, 1'b0, '0, '0, a);
      chk("wrap_adr7", adr7, curAdr + 34'h38);
      chk("wrap_cnt", cntOut, 3'd0);
    end

    // Random traffic against the model
    curRw = 2'b00; curAdr = '0; gap = 0;
    for (int c = 0; c < 3000; c++) begin
      cycle(1'b0, curRw, curAdr, ($urandom_range(2, 0) != 0), {$urandom, $urandom},
            {$urandom, $urandom}, a);
      if (a) begin
        if (curRw == 2'b11) curRw = 2'b10;
        else if ($urandom_range(1, 0) == 1) begin
          curRw = 2'($urandom_range(3, 1));
          curAdr = {PA'($urandom), 6'b0};
        end else begin
          curRw = 2'b00; gap = $urandom_range(2, 0);
        end
      end else if (curRw == 2'b00) begin
        if (gap == 0) begin
          curRw = 2'($urandom_range(3, 1));
          curAdr = {PA'({$urandom, $urandom} >> 6), 6'b0};
        end else gap--;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
